dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//   Data-memory access stage downstream of mux_dmem_data. Takes one load/store request per
//   transaction, with store data already selected by the mux. Drives a req/gnt/rvalid
//   memory port with aligned address, byte mask and lane-replicated write data. Returns
//   sign/zero-extended load data, or a store completion, as a one-cycle io_resp_valid pulse.
//   Holds io_req_ready low while busy so the pipeline stalls.
// PARAMETERS
//   ADDR_W   32   byte-address width. Data width is fixed at 32.
// PORTS
//   clock            in   1       single clock, rising edge
//   reset            in   1       asynchronous, active-low
//   io_req_valid     in   1       request present
//   io_req_ready     out  1       1 only in IDLE
//   io_req_is_store  in   1       1=store, 0=load
//   io_req_funct3    in   3       RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   io_req_addr      in   ADDR_W  byte address
//   io_req_wdata     in   32      store data from mux_dmem_data
//   io_mem_req       out  1       memory request, held until io_mem_gnt
//   io_mem_we        out  1       write enable
//   io_mem_addr      out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
//   io_mem_wmask     out  4       byte enables (0 for loads)
//   io_mem_wdata     out  32      lane-replicated store data
//   io_mem_gnt       in   1       request accepted this cycle
//   io_mem_rvalid    in   1       read data valid, earliest 1 cycle after gnt
//   io_mem_rdata     in   32      read word
//   io_resp_valid    out  1       one-cycle completion pulse
//   io_resp_data     out  32      formatted load data (0 for stores)
//   io_misalign      out  1       valid with io_resp_valid
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE. All outputs 0 except io_req_ready=1.
//     Request regs are cleared.
//   FSM states: IDLE, REQ, WAIT, RESP.
//   IDLE: when io_req_valid=1, latch is_store, funct3, addr, wdata. Next state is REQ.
//   REQ: io_mem_* driven from the latched regs and stable until io_mem_gnt.
//     On gnt: store goes to RESP, load goes to WAIT. io_mem_rvalid is ignored in REQ.
//   WAIT: on io_mem_rvalid, register the formatted data and go to RESP.
//     Wait is unbounded.
//   RESP: io_resp_valid=1 for exactly one cycle, then IDLE. The next request can be
//     accepted the cycle after RESP.
//   Latency from accept edge, with gnt and rvalid at their earliest:
//     store resp_valid 2 cycles later; load 3 cycles later.
//   Store lanes (a = addr[1:0]):
//     SB: mask = 4'b0001<<a, wdata = {4{wdata[7:0]}}
//     SH: mask = 4'b0011<<{a[1],1'b0}, wdata = {2{wdata[15:0]}}
//     SW: mask = 4'b1111
//   Load extract: byte at rdata[8a+:8]; half at rdata[16*a[1]+:16]; word is rdata.
//     B/H sign-extend; BU/HU zero-extend.
//   funct3 011/110/111 are treated as 010 (word).
//   io_mem_rvalid in IDLE/REQ/RESP is ignored, including stale data after reset.
//   Reset mid-transaction: abort immediately, io_mem_req drops asynchronously,
//     and no io_resp_valid is produced.
// CONFIGURATION
//   DMEM_MISALIGN_TRAP_EN defined:
//     - Misaligned means H with a[0]=1, or W with a!=0.
//     - A misaligned request skips REQ/WAIT (no memory access) and goes IDLE->RESP.
//     - In RESP it gives io_misalign=1 and io_resp_data=0.
//   Not defined: io_misalign is tied 0. Offending low address bits are ignored
//     (H uses a[1] only, W uses neither). The access proceeds normally.
// STRUCTURE
//   Package dmem_pkg holds:
//     - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//     - state enum (S_IDLE, S_REQ, S_WAIT, S_RESP)
//     - function store_mask(funct3, a)
//   Sub-module dmem_load_align: combinational rdata + funct3 + a -> 32-bit extended result.
// TESTING
//   1 SB addr=0x1003 wdata=0x000000A5, gnt next cycle -> mem_addr=0x1000,
//     wmask=4'b1000, wdata=0xA5A5A5A5, we=1, resp_valid 2 cycles after accept.
//   2 LB addr=0x2001, rdata=0x00008000 -> resp_data=0xFFFFFF80.
//     Same rdata with LBU -> 0x00000080.
//   3 LH addr=0x2002, rdata=0x8001_1234 -> 0xFFFF8001.
//     gnt held low 3 cycles: mem_req, addr and mask stay stable.
//   4 LW with rvalid delayed 5 cycles: io_req_ready stays 0 throughout,
//     and a req_valid pulse presented meanwhile is not accepted.
//   5 SW addr=0x3002: with the macro, no mem_req and resp_valid with misalign=1
//     1 cycle after accept; without the macro, mem_addr=0x3000, wmask=4'hF.
//   6 Assert reset in WAIT, then deassert; a late rvalid arrives:
//     state is IDLE, no resp_valid, io_req_ready=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory access unit
// Contents: funct3 encodings, FSM state enum, store byte-mask and misalignment helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // funct3[1:0] carries the access size; 011/110/111 fall into the word case.
    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3[1:0])
            2'b00:   store_mask = 4'b0001 << a;
            2'b01:   store_mask = 4'b0011 << {a[1], 1'b0};
            default: store_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - extracts and extends the addressed byte/half/word of a read word
// Ports: rdata (read word), funct3 (width/sign), a (byte offset) -> result (extended data).
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  a,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{a, 3'b000} +: 8];
        // Only a[1] selects the half; a stray a[0] is ignored here.
        half_sel = rdata[{a[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'b0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'b0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - one-at-a-time load/store engine on a req/gnt/rvalid memory port
// Ports: clock, reset (async active-low); io_req_* request handshake and payload;
//        io_mem_* memory port (req/we/addr/wmask/wdata out, gnt/rvalid/rdata in);
//        io_resp_valid/io_resp_data/io_misalign one-cycle completion.
// Option: DMEM_MISALIGN_TRAP_EN makes misaligned H/W requests complete without a
//         memory access and report io_misalign.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic              io_req_is_store,
    input  logic [2:0]        io_req_funct3,
    input  logic [ADDR_W-1:0] io_req_addr,
    input  logic [31:0]       io_req_wdata,
    output logic              io_mem_req,
    output logic              io_mem_we,
    output logic [ADDR_W-1:0] io_mem_addr,
    output logic [3:0]        io_mem_wmask,
    output logic [31:0]       io_mem_wdata,
    input  logic              io_mem_gnt,
    input  logic              io_mem_rvalid,
    input  logic [31:0]       io_mem_rdata,
    output logic              io_resp_valid,
    output logic [31:0]       io_resp_data,
    output logic              io_misalign
);

    state_t            state_q, state_d;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       resp_data_q;
    logic [31:0]       load_result;
    logic [31:0]       store_lanes;
    logic              req_misaligned;
    logic              accept;

    assign accept = (state_q == S_IDLE) && io_req_valid;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign_q;

    assign req_misaligned = is_misaligned(io_req_funct3, io_req_addr[1:0]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (accept) begin
            misalign_q <= req_misaligned;
        end
    end

    assign io_misalign = (state_q == S_RESP) && misalign_q;
`else
    assign req_misaligned = 1'b0;
    assign io_misalign    = 1'b0;
`endif

    dmem_load_align u_load_align (
        .rdata  (io_mem_rdata),
        .funct3 (funct3_q),
        .a      (addr_q[1:0]),
        .result (load_result)
    );

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   store_lanes = {4{wdata_q[7:0]}};
            2'b01:   store_lanes = {2{wdata_q[15:0]}};
            default: store_lanes = wdata_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response data is zeroed on accept so stores and trapped requests return 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            resp_data_q <= 32'h0;
        end else if (accept) begin
            is_store_q  <= io_req_is_store;
            funct3_q    <= io_req_funct3;
            addr_q      <= io_req_addr;
            wdata_q     <= io_req_wdata;
            resp_data_q <= 32'h0;
        end else if ((state_q == S_WAIT) && io_mem_rvalid) begin
            resp_data_q <= load_result;
        end
    end

    // Memory-port outputs decode straight from state_q, so an asynchronous reset
    // drops io_mem_req without waiting for a clock edge.
    always_comb begin
        state_d       = state_q;
        io_req_ready  = 1'b0;
        io_mem_req    = 1'b0;
        io_mem_we     = 1'b0;
        io_mem_addr   = '0;
        io_mem_wmask  = 4'b0000;
        io_mem_wdata  = 32'h0;
        io_resp_valid = 1'b0;
        io_resp_data  = 32'h0;
        case (state_q)
            S_IDLE: begin
                io_req_ready = 1'b1;
                if (io_req_valid) begin
                    state_d = req_misaligned ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                io_mem_req  = 1'b1;
                io_mem_we   = is_store_q;
                io_mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                if (is_store_q) begin
                    io_mem_wmask = store_mask(funct3_q, addr_q[1:0]);
                    io_mem_wdata = store_lanes;
                end
                if (io_mem_gnt) begin
                    state_d = is_store_q ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (io_mem_rvalid) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                io_resp_valid = 1'b1;
                io_resp_data  = resp_data_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - randomized self-checking bench for dmem_access_unit
module tb_dmem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_req_valid;
    logic        io_req_ready;
    logic        io_req_is_store;
    logic [2:0]  io_req_funct3;
    logic [31:0] io_req_addr;
    logic [31:0] io_req_wdata;
    logic        io_mem_req;
    logic        io_mem_we;
    logic [31:0] io_mem_addr;
    logic [3:0]  io_mem_wmask;
    logic [31:0] io_mem_wdata;
    logic        io_mem_gnt;
    logic        io_mem_rvalid;
    logic [31:0] io_mem_rdata;
    logic        io_resp_valid;
    logic [31:0] io_resp_data;
    logic        io_misalign;

    always #5 clock = ~clock;

    dmem_access_unit #(.ADDR_W(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_req_valid    (io_req_valid),
        .io_req_ready    (io_req_ready),
        .io_req_is_store (io_req_is_store),
        .io_req_funct3   (io_req_funct3),
        .io_req_addr     (io_req_addr),
        .io_req_wdata    (io_req_wdata),
        .io_mem_req      (io_mem_req),
        .io_mem_we       (io_mem_we),
        .io_mem_addr     (io_mem_addr),
        .io_mem_wmask    (io_mem_wmask),
        .io_mem_wdata    (io_mem_wdata),
        .io_mem_gnt      (io_mem_gnt),
        .io_mem_rvalid   (io_mem_rvalid),
        .io_mem_rdata    (io_mem_rdata),
        .io_resp_valid   (io_resp_valid),
        .io_resp_data    (io_resp_data),
        .io_misalign     (io_misalign)
    );

    int errors = 0;
    int checks = 0;

    // Expected transaction phase for the current cycle: -1 none, 0 idle,
    // 1 memory request, 2 waiting for read data, 3 response.
    int          exp_phase = -1;
    logic [31:0] exp_maddr = 32'h0;
    logic        exp_we    = 1'b0;
    logic [3:0]  exp_mask  = 4'h0;
    logic [31:0] exp_mwdata = 32'h0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_mis   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit trap_on();
`ifdef DMEM_MISALIGN_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Access size in bytes.
    function automatic int size_of(input logic st, input logic [2:0] f3);
        if (st) begin
            if (f3 == 3'd0) return 1;
            if (f3 == 3'd1) return 2;
            return 4;
        end
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit model_misaligned(input int sz, input logic [1:0] a);
        if (!trap_on()) return 1'b0;
        if (sz == 2) return (a % 2) != 0;
        if (sz == 4) return a != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_mask(input int sz, input logic [1:0] a);
        if (sz == 1) return 4'(1 << a);
        if (sz == 2) return (a >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_store_data(input int sz, input logic [31:0] wd);
        if (sz == 1) return {24'h0, wd[7:0]} * 32'h01010101;
        if (sz == 2) return {16'h0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
        int          sz;
        int          off;
        logic [31:0] v;
        sz = size_of(1'b0, f3);
        if (sz == 4) return rd;
        off = (sz == 1) ? int'(a) : int'(a & 2'b10);
        v = (rd >> (8 * off)) & ((32'd1 << (8 * sz)) - 32'd1);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (32'd1 << (8 * sz - 1)))
            v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    always @(negedge clock) begin
        if (exp_phase >= 0) begin
            check("req_ready", 32'(io_req_ready), 32'(exp_phase == 0));
            check("mem_req", 32'(io_mem_req), 32'(exp_phase == 1));
            check("resp_valid", 32'(io_resp_valid), 32'(exp_phase == 3));
            if (exp_phase == 1) begin
                check("mem_addr", io_mem_addr, exp_maddr);
                check("mem_we", 32'(io_mem_we), 32'(exp_we));
                check("mem_wmask", 32'(io_mem_wmask), 32'(exp_mask));
                if (exp_we) check("mem_wdata", io_mem_wdata, exp_mwdata);
            end
            if (exp_phase == 3) begin
                check("resp_data", io_resp_data, exp_rdata);
                check("misalign", 32'(io_misalign), 32'(exp_mis));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycle();
        exp_phase     = 0;
        io_req_valid  = 1'b0;
        io_mem_gnt    = 1'b0;
        io_mem_rvalid = 1'($urandom % 2);
        io_mem_rdata  = $urandom;
        step();
    endtask

    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int gd, input int rvd, input bit poke);
        int         sz;
        logic [1:0] a;
        sz = size_of(st, f3);
        a  = addr[1:0];

        exp_phase       = 0;
        io_req_valid    = 1'b1;
        io_req_is_store = st;
        io_req_funct3   = f3;
        io_req_addr     = addr;
        io_req_wdata    = wd;
        io_mem_gnt      = 1'b0;
        io_mem_rvalid   = 1'($urandom % 2);
        io_mem_rdata    = $urandom;
        step();

        io_req_valid    = 1'b0;
        io_req_is_store = 1'($urandom % 2);
        io_req_funct3   = 3'($urandom);
        io_req_addr     = $urandom;
        io_req_wdata    = $urandom;

        if (model_misaligned(sz, a)) begin
            exp_phase     = 3;
            exp_rdata     = 32'h0;
            exp_mis       = 1'b1;
            io_mem_rvalid = 1'($urandom % 2);
            step();
            return;
        end

        exp_maddr  = {addr[31:2], 2'b00};
        exp_we     = st;
        exp_mask   = st ? model_mask(sz, a) : 4'h0;
        exp_mwdata = model_store_data(sz, wd);
        for (int k = 0; k <= gd; k++) begin
            exp_phase     = 1;
            io_mem_gnt    = (k == gd);
            io_mem_rvalid = 1'($urandom % 2);
            io_mem_rdata  = $urandom;
            io_req_valid  = poke && (k == 0);
            step();
        end
        io_mem_gnt   = 1'b0;
        io_req_valid = 1'b0;

        if (!st) begin
            for (int k = 0; k <= rvd; k++) begin
                exp_phase     = 2;
                io_mem_rvalid = (k == rvd);
                io_mem_rdata  = (k == rvd) ? rd : $urandom;
                io_req_valid  = poke && (k == 0);
                step();
            end
            io_req_valid = 1'b0;
        end

        exp_phase     = 3;
        exp_rdata     = st ? 32'h0 : model_load(f3, a, rd);
        exp_mis       = 1'b0;
        io_mem_rvalid = 1'($urandom % 2);
        io_mem_rdata  = $urandom;
        step();
    endtask

    // Abort a load with reset, either while requesting or while waiting for data.
    task automatic reset_abort(input bit in_wait);
        exp_phase       = 0;
        io_req_valid    = 1'b1;
        io_req_is_store = 1'b0;
        io_req_funct3   = 3'd2;
        io_req_addr     = {$urandom, 2'b00};
        io_mem_gnt      = 1'b0;
        io_mem_rvalid   = 1'b0;
        step();
        io_req_valid = 1'b0;
        exp_phase    = -1;
        if (in_wait) begin
            io_mem_gnt = 1'b1;
            step();
            io_mem_gnt = 1'b0;
        end else begin
            check("abort_req_before", 32'(io_mem_req), 32'd1);
        end
        #1;
        reset = 1'b0;
        #1;
        check("abort_mem_req", 32'(io_mem_req), 32'd0);
        check("abort_ready", 32'(io_req_ready), 32'd1);
        check("abort_resp_valid", 32'(io_resp_valid), 32'd0);
        step();
        reset         = 1'b1;
        exp_phase     = 0;
        io_mem_rvalid = 1'b1;
        io_mem_rdata  = $urandom;
        step();
        io_mem_rvalid = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [2:0] store_f3 [6];
        store_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

        reset           = 1'b0;
        io_req_valid    = 1'b0;
        io_req_is_store = 1'b0;
        io_req_funct3   = 3'd0;
        io_req_addr     = 32'h0;
        io_req_wdata    = 32'h0;
        io_mem_gnt      = 1'b0;
        io_mem_rvalid   = 1'b1;
        io_mem_rdata    = 32'hDEADBEEF;
        #2;
        check("rst_ready", 32'(io_req_ready), 32'd1);
        check("rst_mem_req", 32'(io_mem_req), 32'd0);
        check("rst_mem_we", 32'(io_mem_we), 32'd0);
        check("rst_mem_addr", io_mem_addr, 32'd0);
        check("rst_mem_wmask", 32'(io_mem_wmask), 32'd0);
        check("rst_mem_wdata", io_mem_wdata, 32'd0);
        check("rst_resp_valid", 32'(io_resp_valid), 32'd0);
        check("rst_resp_data", io_resp_data, 32'd0);
        check("rst_misalign", 32'(io_misalign), 32'd0);
        step();
        step();
        reset         = 1'b1;
        io_mem_rvalid = 1'b0;
        idle_cycle();

        // Pin the model against hand-computed values.
        check("pin_sb_mask", 32'(model_mask(1, 2'd3)), 32'h8);
        check("pin_sb_wdata", model_store_data(1, 32'h000000A5), 32'hA5A5A5A5);
        check("pin_lb", model_load(3'd0, 2'd1, 32'h00008000), 32'hFFFFFF80);
        check("pin_lbu", model_load(3'd4, 2'd1, 32'h00008000), 32'h00000080);
        check("pin_lh", model_load(3'd1, 2'd2, 32'h80011234), 32'hFFFF8001);
        check("pin_sh_mask", 32'(model_mask(2, 2'd2)), 32'hC);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("pin_sw_mis", 32'(model_misaligned(4, 2'd2)), 32'd1);
`else
        check("pin_sw_mask", 32'(model_mask(4, 2'd2)), 32'hF);
`endif

        txn(1'b1, 3'd0, 32'h00001003, 32'h000000A5, 32'h0, 0, 0, 1'b0);
        idle_cycle();
        txn(1'b0, 3'd0, 32'h00002001, 32'h0, 32'h00008000, 0, 0, 1'b0);
        txn(1'b0, 3'd4, 32'h00002001, 32'h0, 32'h00008000, 0, 0, 1'b0);
        txn(1'b0, 3'd1, 32'h00002002, 32'h0, 32'h80011234, 3, 0, 1'b0);
        txn(1'b0, 3'd2, 32'h00004000, 32'h0, 32'h12345678, 0, 5, 1'b1);
        idle_cycle();
        txn(1'b1, 3'd2, 32'h00003002, 32'hCAFEF00D, 32'h0, 0, 0, 1'b0);
        idle_cycle();
        reset_abort(1'b1);
        reset_abort(1'b0);

        for (int n = 0; n < 200; n++) begin
            logic        st;
            logic [2:0]  f3;
            st = 1'($urandom % 2);
            f3 = st ? store_f3[$urandom % 6] : 3'($urandom);
            txn(st, f3, $urandom, $urandom, $urandom,
                int'($urandom % 4), int'($urandom % 4), ($urandom % 4) == 0);
            for (int g = 0; g < int'($urandom % 3); g++) idle_cycle();
        end

        exp_phase = -1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
